keypad_encoder: RTL and testbench



---
 rtl/keypad_encoder.sv | 121 ++++++++++++
 tb/tb_keypad_encoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// Eight key lines in, one {code_valid, code} event out per debounced press.
// Two-flop synchroniser, press/release debounce FSM, lowest-index priority encode.
module keypad_encoder #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keys,
  output logic [2:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       s1;
  logic [7:0]       keys_s;
  logic [7:0]       sample;
  logic [CNT_W-1:0] cnt;
  logic             press_done;
  logic             accept;

  // Index of the lowest set bit; bit 0 wins when several keys are down.
  function automatic logic [2:0] enc(input logic [7:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (x[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    press_done = (state == PRESS_DB) && (keys_s != 8'd0) &&
                 (keys_s == sample) && (cnt == CNT_MAX);
    accept     = code_valid && code_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1         <= 8'd0;
      keys_s     <= 8'd0;
      sample     <= 8'd0;
      cnt        <= '0;
      state      <= IDLE;
      code       <= 3'd0;
      code_valid <= 1'b0;
      key_held   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      s1       <= keys;
      keys_s   <= s1;
      overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (keys_s != 8'd0) begin
            sample <= keys_s;
            cnt    <= '0;
            state  <= PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (keys_s == 8'd0) begin
            state <= IDLE;
          end else if (keys_s != sample) begin
            // A bounce or a different key restarts the stability window.
            sample <= keys_s;
            cnt    <= '0;
          end else if (cnt == CNT_MAX) begin
            state    <= HELD;
            key_held <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (keys_s == 8'd0) begin
            cnt   <= '0;
            state <= REL_DB;
          end
        end
        REL_DB: begin
          if (keys_s != 8'd0) begin
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            state    <= IDLE;
            key_held <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A pending event is never overwritten unless it is accepted this cycle.
      if (press_done) begin
        if (!code_valid || code_ready) begin
          code       <= enc(sample);
          code_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (accept) begin
        code_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with DEBOUNCE_CYCLES=4; expectations are hand-derived edge counts.
module tb_keypad_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] keys;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic       key_held;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  keypad_encoder #(
    .CNT_W           (16),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys       (keys),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .key_held   (key_held),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {7'd0, code_valid}, 8'd0);
    check({tag, "_held"},  {7'd0, key_held},   8'd0);
    check({tag, "_ovf"},   {7'd0, overflow},   8'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    keys       = 8'h00;
    code_ready = 1'b0;
    step(2);
    check_idle_outputs("rst");
    check("rst_code", {5'd0, code}, 8'd0);
    rst_n = 1'b1;

    // 1: no keys for 20 cycles
    for (int e = 1; e <= 20; e++) begin
      step(1);
      check_idle_outputs("quiet");
    end
    check("quiet_code", {5'd0, code}, 8'd0);

    // 2: key 3, consumer always ready, event after edge 7 for one cycle
    keys       = 8'h08;
    code_ready = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      if (e < 7) check("s2_valid_early", {7'd0, code_valid}, 8'd0);
      if (e == 7) begin
        check("s2_valid", {7'd0, code_valid}, 8'd1);
        check("s2_code",  {5'd0, code},       8'd3);
        check("s2_held",  {7'd0, key_held},   8'd1);
      end
      if (e == 8) begin
        check("s2_valid_drop", {7'd0, code_valid}, 8'd0);
        check("s2_held_still", {7'd0, key_held},   8'd1);
      end
    end
    keys = 8'h00;
    step(6);
    check("s2_rel_held", {7'd0, key_held}, 8'd1);
    step(1);
    check("s2_rel_done", {7'd0, key_held}, 8'd0);

    // 3: pending event blocks a second press, which overflows
    code_ready = 1'b0;
    keys       = 8'h24;
    step(7);
    check("s3_valid", {7'd0, code_valid}, 8'd1);
    check("s3_code",  {5'd0, code},       8'd2);
    step(3);
    check("s3_valid_hold", {7'd0, code_valid}, 8'd1);
    keys = 8'h00;
    step(8);
    check("s3_rel_held",  {7'd0, key_held},   8'd0);
    check("s3_rel_valid", {7'd0, code_valid}, 8'd1);
    keys = 8'h80;
    step(6);
    check("s3_ovf_early", {7'd0, overflow}, 8'd0);
    step(1);
    check("s3_ovf",       {7'd0, overflow},   8'd1);
    check("s3_ovf_code",  {5'd0, code},       8'd2);
    check("s3_ovf_valid", {7'd0, code_valid}, 8'd1);
    step(1);
    check("s3_ovf_pulse", {7'd0, overflow},   8'd0);
    code_ready = 1'b1;
    step(1);
    check("s3_accept", {7'd0, code_valid}, 8'd0);
    check("s3_code_kept", {5'd0, code}, 8'd2);
    keys = 8'h00;
    step(8);
    check("s3_idle_held", {7'd0, key_held}, 8'd0);

    // 4: bouncing key never qualifies, then settles
    for (int c = 0; c < 20; c++) begin
      keys = ((c / 2) % 2 == 0) ? 8'h01 : 8'h00;
      step(1);
      check("s4_bounce_valid", {7'd0, code_valid}, 8'd0);
      check("s4_bounce_held",  {7'd0, key_held},   8'd0);
    end
    keys = 8'h01;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      if (e < 7) check("s4_valid_early", {7'd0, code_valid}, 8'd0);
    end
    check("s4_valid", {7'd0, code_valid}, 8'd1);
    check("s4_code",  {5'd0, code},       8'd0);
    keys = 8'h00;
    step(10);
    check("s4_idle", {7'd0, key_held}, 8'd0);

    // 5: short release glitch while held is absorbed
    keys = 8'h02;
    step(7);
    check("s5_valid", {7'd0, code_valid}, 8'd1);
    check("s5_code",  {5'd0, code},       8'd1);
    keys = 8'h00;
    step(2);
    keys = 8'h02;
    for (int e = 1; e <= 10; e++) begin
      step(1);
      check("s5_glitch_held",  {7'd0, key_held},   8'd1);
      check("s5_glitch_valid", {7'd0, code_valid}, 8'd0);
    end
    keys = 8'h00;
    step(10);
    check("s5_rel_held", {7'd0, key_held}, 8'd0);
    keys = 8'h40;
    step(6);
    check("s5_second_early", {7'd0, code_valid}, 8'd0);
    step(1);
    check("s5_second_valid", {7'd0, code_valid}, 8'd1);
    check("s5_second_code",  {5'd0, code},       8'd6);
    keys = 8'h00;
    step(10);

    // 6: reset mid press-debounce restarts everything
    keys = 8'h10;
    step(5);
    rst_n = 1'b0;
    step(1);
    check_idle_outputs("s6_rst");
    check("s6_rst_code", {5'd0, code}, 8'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      if (e < 7) check("s6_valid_early", {7'd0, code_valid}, 8'd0);
    end
    check("s6_valid", {7'd0, code_valid}, 8'd1);
    check("s6_code",  {5'd0, code},       8'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
